// File: rtl/id_ex_pipeline_reg_if.sv
// ID/EX boundary bundle: decoded instruction from ID, registered copy to EX,
// plus the pipeline control and hazard status that travel with it.
interface id_ex_pipeline_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 10
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;

  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              load_use_stall;
  logic [15:0]       bubble_count;

  // Master is the pipeline around the register (ID side and EX consumers).
  modport master (
    output stall, flush, id_valid, id_ctrl, id_uses_rt, id_pc4,
           id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    input  ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, load_use_stall, bubble_count
  );

  modport slave (
    input  stall, flush, id_valid, id_ctrl, id_uses_rt, id_pc4,
           id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
    output ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, load_use_stall, bubble_count
  );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register of the MIPS32 core with load-use hazard detection.
// Inserts a bubble on flush or load-use, holds on stall, counts bubbles (saturating).
module id_ex_pipeline_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 10
) (
  input logic                 clock,
  input logic                 reset,
  id_ex_pipeline_reg_if.slave bus
);
  localparam int          CTRL_MEM_READ = 8;
  localparam logic [15:0] COUNT_MAX     = 16'hFFFF;

  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic [15:0]       bubble_count;

  logic rs_match;
  logic rt_match;
  logic hazard;
  logic insert_bubble;

  // A load in EX whose destination (rt, never $zero) feeds the ID instruction.
  always_comb begin
    rs_match      = (ex_rt == bus.id_rs);
    rt_match      = bus.id_uses_rt && (ex_rt == bus.id_rt);
    hazard        = ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_rt != '0) &&
                    bus.id_valid && (rs_match || rt_match);
    insert_bubble = bus.flush || (!bus.stall && hazard);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= '0;
      ex_pc4       <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      bubble_count <= '0;
    end else if (insert_bubble) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      if (bubble_count != COUNT_MAX) begin
        bubble_count <= bubble_count + 16'd1;
      end
    end else if (!bus.stall) begin
      // Control is zeroed for an empty slot so EX can never issue a write.
      ex_valid   <= bus.id_valid;
      ex_ctrl    <= bus.id_valid ? bus.id_ctrl : '0;
      ex_pc4     <= bus.id_pc4;
      ex_rs_data <= bus.id_rs_data;
      ex_rt_data <= bus.id_rt_data;
      ex_imm     <= bus.id_imm;
      ex_rs      <= bus.id_rs;
      ex_rt      <= bus.id_rt;
      ex_rd      <= bus.id_rd;
    end
  end

  assign bus.ex_valid       = ex_valid;
  assign bus.ex_ctrl        = ex_ctrl;
  assign bus.ex_pc4         = ex_pc4;
  assign bus.ex_rs_data     = ex_rs_data;
  assign bus.ex_rt_data     = ex_rt_data;
  assign bus.ex_imm         = ex_imm;
  assign bus.ex_rs          = ex_rs;
  assign bus.ex_rt          = ex_rt;
  assign bus.ex_rd          = ex_rd;
  assign bus.bubble_count   = bubble_count;
  assign bus.load_use_stall = hazard && !bus.stall;
endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: directed scenarios followed by
// randomized traffic, all compared against an instruction-level reference model.
module tb_id_ex_pipeline_reg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 10;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } instr_t;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  id_ex_pipeline_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) bus ();

  id_ex_pipeline_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int     checks = 0;
  int     errors = 0;
  instr_t m_ex   = '0;
  longint m_bubbles = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // The EX instruction is a load whose result the ID instruction needs.
  function automatic bit loadUse(input instr_t ex, input instr_t id, input bit uses_rt);
    return ex.valid && ex.ctrl[8] && (ex.rt != 0) && id.valid &&
           ((ex.rt == id.rs) || (uses_rt && (ex.rt == id.rt)));
  endfunction

  function automatic instr_t mkInstr(input bit v, input logic [CTRL_W-1:0] c,
                                     input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    instr_t i;
    i.valid = v; i.ctrl = c; i.rs = rs; i.rt = rt; i.rd = rd;
    i.rs_data = a; i.rt_data = b;
    i.pc4 = $urandom & 32'hFFFF_FFFC;
    i.imm = $urandom;
    return i;
  endfunction

  function automatic logic [REG_AW-1:0] randReg();
    return ($urandom_range(0, 3) == 0) ? REG_AW'($urandom) : REG_AW'($urandom_range(0, 3));
  endfunction

  function automatic instr_t randInstr();
    return mkInstr($urandom_range(0, 7) != 0, CTRL_W'($urandom), randReg(), randReg(),
                   randReg(), $urandom, $urandom);
  endfunction

  task automatic checkEx();
    longint sat;
    sat = (m_bubbles > 65535) ? 65535 : m_bubbles;
    checkOutput("ex_valid", 64'(bus.ex_valid), 64'(m_ex.valid));
    checkOutput("ex_ctrl", 64'(bus.ex_ctrl), 64'(m_ex.ctrl));
    checkOutput("ex_pc4", 64'(bus.ex_pc4), 64'(m_ex.pc4));
    checkOutput("ex_rs_data", 64'(bus.ex_rs_data), 64'(m_ex.rs_data));
    checkOutput("ex_rt_data", 64'(bus.ex_rt_data), 64'(m_ex.rt_data));
    checkOutput("ex_imm", 64'(bus.ex_imm), 64'(m_ex.imm));
    checkOutput("ex_rs", 64'(bus.ex_rs), 64'(m_ex.rs));
    checkOutput("ex_rt", 64'(bus.ex_rt), 64'(m_ex.rt));
    checkOutput("ex_rd", 64'(bus.ex_rd), 64'(m_ex.rd));
    checkOutput("bubble_count", 64'(bus.bubble_count), 64'(sat));
  endtask

  // One clock: drive at negedge, check the combinational stall, clock, check EX.
  task automatic applyStimulus(input bit rst, input bit st, input bit fl,
                               input instr_t id, input bit uses_rt, output bit stall_seen);
    bit hz;
    @(negedge clock);
    reset          = rst;
    bus.stall      = st;
    bus.flush      = fl;
    bus.id_valid   = id.valid;
    bus.id_ctrl    = id.ctrl;
    bus.id_uses_rt = uses_rt;
    bus.id_pc4     = id.pc4;
    bus.id_rs_data = id.rs_data;
    bus.id_rt_data = id.rt_data;
    bus.id_imm     = id.imm;
    bus.id_rs      = id.rs;
    bus.id_rt      = id.rt;
    bus.id_rd      = id.rd;
    #1;
    hz = loadUse(m_ex, id, uses_rt);
    stall_seen = bus.load_use_stall;
    checkOutput("load_use_stall", 64'(bus.load_use_stall), 64'(hz && !st));
    @(posedge clock);
    if (rst) begin
      m_ex = '0;
      m_bubbles = 0;
    end else if (fl || (hz && !st)) begin
      m_ex = '0;
      m_bubbles++;
    end else if (!st) begin
      m_ex = id;
      if (!id.valid) m_ex.ctrl = '0;
    end
    #1;
    checkEx();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    instr_t i;
    instr_t lw;
    instr_t dep;
    bit     s;
    logic [DATA_W-1:0] held_pc4;
    logic [15:0]       cnt;

    // Reset held two cycles with a fully-asserted control bundle on ID.
    i = mkInstr(1, 10'h3FF, 5'd1, 5'd2, 5'd3, 32'h1111_1111, 32'h2222_2222);
    reset = 1'b1;
    bus.stall = 0; bus.flush = 0; bus.id_valid = 1; bus.id_ctrl = i.ctrl;
    bus.id_uses_rt = 1; bus.id_pc4 = i.pc4; bus.id_rs_data = i.rs_data;
    bus.id_rt_data = i.rt_data; bus.id_imm = i.imm;
    bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd;
    @(posedge clock);
    applyStimulus(1, 0, 0, i, 1, s);
    checkOutput("reset_ex_valid", 64'(bus.ex_valid), 64'd0);
    checkOutput("reset_ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
    checkOutput("reset_count", 64'(bus.bubble_count), 64'd0);
    checkOutput("reset_stall_out", 64'(bus.load_use_stall), 64'd0);

    // Plain OR instruction lands one cycle later.
    i = mkInstr(1, 10'h201, 5'd4, 5'd5, 5'd9, 32'h0F0F_0000, 32'h0000_F0F0);
    applyStimulus(0, 0, 0, i, 1, s);
    checkOutput("or_ex_valid", 64'(bus.ex_valid), 64'd1);
    checkOutput("or_ex_ctrl", 64'(bus.ex_ctrl), 64'h201);
    checkOutput("or_rs_data", 64'(bus.ex_rs_data), 64'h0F0F_0000);
    checkOutput("or_rt_data", 64'(bus.ex_rt_data), 64'h0000_F0F0);
    checkOutput("or_ex_rd", 64'(bus.ex_rd), 64'd9);

    // lw $8 followed by a consumer of $8: one bubble, then the consumer lands.
    lw  = mkInstr(1, 10'h362, 5'd1, 5'd8, 5'd0, $urandom, $urandom);
    dep = mkInstr(1, 10'h202, 5'd8, 5'd2, 5'd3, $urandom, $urandom);
    applyStimulus(0, 0, 0, lw, 0, s);
    applyStimulus(0, 0, 0, dep, 1, s);
    checkOutput("lu_stall_out", 64'(s), 64'd1);
    checkOutput("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
    checkOutput("lu_bubble_ctrl", 64'(bus.ex_ctrl), 64'd0);
    checkOutput("lu_count", 64'(bus.bubble_count), 64'd1);
    applyStimulus(0, 0, 0, dep, 1, s);
    checkOutput("lu_released", 64'(s), 64'd0);
    checkOutput("lu_dep_lands", 64'(bus.ex_rs), 64'd8);

    // lw into $zero never stalls; rt match is ignored when rt is not a source.
    lw  = mkInstr(1, 10'h362, 5'd1, 5'd0, 5'd0, $urandom, $urandom);
    dep = mkInstr(1, 10'h202, 5'd0, 5'd0, 5'd3, $urandom, $urandom);
    applyStimulus(0, 0, 0, lw, 0, s);
    applyStimulus(0, 0, 0, dep, 1, s);
    checkOutput("lw_zero_no_stall", 64'(s), 64'd0);
    lw  = mkInstr(1, 10'h362, 5'd1, 5'd8, 5'd0, $urandom, $urandom);
    dep = mkInstr(1, 10'h2A2, 5'd3, 5'd8, 5'd0, $urandom, $urandom);
    applyStimulus(0, 0, 0, lw, 0, s);
    applyStimulus(0, 0, 0, dep, 0, s);
    checkOutput("rt_unused_no_stall", 64'(s), 64'd0);

    // Stall holds EX for three cycles; flush wins over a simultaneous stall.
    held_pc4 = bus.ex_pc4;
    cnt = bus.bubble_count;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, randInstr(), 1, s);
      checkOutput("stall_hold_pc4", 64'(bus.ex_pc4), 64'(held_pc4));
      checkOutput("stall_no_lu", 64'(s), 64'd0);
    end
    applyStimulus(0, 1, 1, randInstr(), 1, s);
    checkOutput("stall_flush_valid", 64'(bus.ex_valid), 64'd0);
    checkOutput("stall_flush_count", 64'(bus.bubble_count), 64'(cnt + 16'd1));

    // Randomized traffic, biased toward load-use pairs.
    for (int n = 0; n < 3000; n++) begin
      i = randInstr();
      if ($urandom_range(0, 1) == 0) i.rs = m_ex.rt;
      if ($urandom_range(0, 3) == 0) i.ctrl[8] = 1'b1;
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 9) == 0, i, $urandom_range(0, 1) == 1, s);
    end

    // Counter saturation across 65537 flushes, cleared only by reset.
    applyStimulus(1, 0, 0, randInstr(), 1, s);
    for (int n = 0; n < 65537; n++) begin
      applyStimulus(0, 0, 1, randInstr(), 1, s);
    end
    checkOutput("sat_count", 64'(bus.bubble_count), 64'hFFFF);
    applyStimulus(0, 1, 1, randInstr(), 1, s);
    checkOutput("sat_holds", 64'(bus.bubble_count), 64'hFFFF);
    applyStimulus(1, 0, 1, randInstr(), 1, s);
    checkOutput("sat_reset", 64'(bus.bubble_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
